// File: rtl/alu_secuenciador_pkg.sv
// Shared state encodings and button indices for the ALU operator-input sequencer.
package alu_secuenciador_pkg;

   localparam int ANCHO_ESTADO = 3;

   typedef enum logic [ANCHO_ESTADO-1:0] {
      ESPERA_A  = 3'd0,
      ESPERA_B  = 3'd1,
      ESPERA_OP = 3'd2,
      EJECUTAR  = 3'd3,
      RESULTADO = 3'd4
   } estado_t;

   localparam int BTN_A        = 0;
   localparam int BTN_B        = 1;
   localparam int BTN_OP       = 2;
   localparam int BTN_CANCELAR = 3;

endpackage

// File: rtl/alu_secuenciador_antirrebote.sv
// One push-button: 2-flop synchronizer, stability-count debounce, 1-cycle pulse on debounced rise.
module antirrebote #(
   parameter int CICLOS_ANTIRREBOTE = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic boton,
   output logic pulso
);

   localparam int ANCHO_CNT = $clog2(CICLOS_ANTIRREBOTE + 1);
   localparam logic [ANCHO_CNT-1:0] LIMITE = ANCHO_CNT'(CICLOS_ANTIRREBOTE - 1);

   logic                 sync1;
   logic                 sync2;
   logic                 nivel;
   logic                 nivel_q;
   logic [ANCHO_CNT-1:0] cnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         nivel   <= 1'b0;
         nivel_q <= 1'b0;
         cnt     <= '0;
         pulso   <= 1'b0;
      end else begin
         sync1   <= boton;
         sync2   <= sync1;
         nivel_q <= nivel;
         pulso   <= nivel & ~nivel_q;
         // The edge that would bring the count to CICLOS_ANTIRREBOTE flips the level instead.
         if (sync2 == nivel) begin
            cnt <= '0;
         end else if (cnt == LIMITE) begin
            nivel <= ~nivel;
            cnt   <= '0;
         end else begin
            cnt <= cnt + ANCHO_CNT'(1);
         end
      end
   end

endmodule

// File: rtl/alu_secuenciador.sv
// Operator-input sequencer: debounced buttons load A, B and opcode in order, then capture the ALU result.
module alu_secuenciador
   import alu_secuenciador_pkg::*;
#(
   parameter int BUS_DATOS          = 4,
   parameter int CANT_BIT_OPCODE    = 4,
   parameter int CANT_BOTONES       = 4,
   parameter int CICLOS_ANTIRREBOTE = 4
) (
   input  logic                       i_clock,
   input  logic                       i_reset,
   input  logic [BUS_DATOS-1:0]       i_switches,
   input  logic [CANT_BOTONES-1:0]    i_botones,
   input  logic [BUS_DATOS-1:0]       i_resultado,
   output logic [BUS_DATOS-1:0]       o_operando_1,
   output logic [BUS_DATOS-1:0]       o_operando_2,
   output logic [CANT_BIT_OPCODE-1:0] o_opcode,
   output logic [BUS_DATOS-1:0]       o_resultado,
   output logic                       o_resultado_valido,
   output logic [ANCHO_ESTADO-1:0]    o_estado,
   output logic                       o_error
);

   logic [CANT_BOTONES-1:0]    pulsos;
   logic                       varios;
   estado_t                    estado, estado_sig;
   logic [BUS_DATOS-1:0]       op1_sig, op2_sig, res_sig;
   logic [CANT_BIT_OPCODE-1:0] opc_sig;
   logic                       error_sig;

   for (genvar g = 0; g < CANT_BOTONES; g++) begin : g_boton
      antirrebote #(.CICLOS_ANTIRREBOTE(CICLOS_ANTIRREBOTE)) u_antirrebote (
         .clock (i_clock),
         .reset (i_reset),
         .boton (i_botones[g]),
         .pulso (pulsos[g])
      );
   end

   assign varios = (pulsos & (pulsos - CANT_BOTONES'(1))) != '0;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         estado             <= ESPERA_A;
         o_operando_1       <= '0;
         o_operando_2       <= '0;
         o_opcode           <= '0;
         o_resultado        <= '0;
         o_resultado_valido <= 1'b0;
         o_error            <= 1'b0;
      end else begin
         estado             <= estado_sig;
         o_operando_1       <= op1_sig;
         o_operando_2       <= op2_sig;
         o_opcode           <= opc_sig;
         o_resultado        <= res_sig;
         o_resultado_valido <= (estado_sig == RESULTADO);
         o_error            <= error_sig;
      end
   end

   assign o_estado = estado;

   always_comb begin
      estado_sig = estado;
      op1_sig    = o_operando_1;
      op2_sig    = o_operando_2;
      opc_sig    = o_opcode;
      res_sig    = o_resultado;
      error_sig  = 1'b0;
      case (estado)
         ESPERA_A, ESPERA_B, ESPERA_OP, RESULTADO: begin
            if (varios) begin
               error_sig = 1'b1;
            end else if (pulsos[BTN_CANCELAR]) begin
               estado_sig = ESPERA_A;
            end else if (pulsos[BTN_A]) begin
               op1_sig = i_switches;
               if (estado inside {ESPERA_A, RESULTADO}) estado_sig = ESPERA_B;
            end else if (pulsos[BTN_B]) begin
               if (estado == ESPERA_A) begin
                  error_sig = 1'b1;
               end else begin
                  op2_sig    = i_switches;
                  estado_sig = ESPERA_OP;
               end
            end else if (pulsos[BTN_OP]) begin
               if (estado inside {ESPERA_A, ESPERA_B}) begin
                  error_sig = 1'b1;
               end else begin
                  opc_sig    = i_switches[CANT_BIT_OPCODE-1:0];
                  estado_sig = EJECUTAR;
               end
            end
         end
         // Pulses arriving here are dropped: the ALU inputs are settled, just capture.
         EJECUTAR: begin
            res_sig    = i_resultado;
            estado_sig = RESULTADO;
         end
         default: estado_sig = ESPERA_A;
      endcase
   end

endmodule

// File: doc/alu_secuenciador.md
Name: alu_secuenciador

Overview:
Operator-input controller for the ALU datapath. It synchronizes and debounces the push-buttons, turns each accepted press into a single-cycle command, and loads operand A, operand B and the opcode in a fixed order. After the opcode is loaded it captures the ALU result into a register and flags it valid. It sits between the board I/O (switches, buttons, LEDs) and the combinational alu instance.

Parameters:
BUS_DATOS, 4, width of switches, operands and result
CANT_BIT_OPCODE, 4, opcode width; must be <= BUS_DATOS (opcode = low bits of switches)
CANT_BOTONES, 4, number of buttons; fixed at 4 (indices 0..3)
CICLOS_ANTIRREBOTE, 4, consecutive stable cycles required to accept a level change; >= 1

Ports:
i_clock  in  1  clock, all logic on rising edge
i_reset  in  1  reset, synchronous, active-high
i_switches  in  BUS_DATOS  operand/opcode source
i_botones  in  CANT_BOTONES  raw asynchronous buttons; 0=load A, 1=load B, 2=load opcode, 3=cancel
i_resultado  in  BUS_DATOS  ALU combinational output
o_operando_1  out  BUS_DATOS  registered operand A to ALU
o_operando_2  out  BUS_DATOS  registered operand B to ALU
o_opcode  out  CANT_BIT_OPCODE  registered opcode to ALU
o_resultado  out  BUS_DATOS  captured result (drives LEDs)
o_resultado_valido  out  1  high while o_resultado corresponds to current operands/opcode
o_estado  out  3  current FSM state encoding
o_error  out  1  one-cycle pulse on rejected command

Behaviour:
- Reset (i_clock with i_reset=1): all outputs 0, state ESPERA_A, synchronizer flops 0, debounced levels 0, debounce counters 0. Reset overrides everything, including mid-sequence.
- Per button: 2-flop synchronizer. Debounce: counter increments each cycle synced level != debounced level, clears when equal; when it reaches CICLOS_ANTIRREBOTE the debounced level flips and the counter clears. Pulse = debounced rising edge, registered, exactly 1 cycle wide. Falling edges give no pulse.
- Latency: raw level stable from edge e0 (first sampling edge) -> pulse high after edge e0+CICLOS_ANTIRREBOTE+2 -> target register updated at edge e0+CICLOS_ANTIRREBOTE+3. Glitches shorter than CICLOS_ANTIRREBOTE cycles are never accepted.
- A button held through reset release is accepted as a new press after debounce.
- If >1 pulse in the same cycle: all ignored, o_error pulses, no state or register change.
- FSM states (encoding): ESPERA_A=0, ESPERA_B=1, ESPERA_OP=2, EJECUTAR=3, RESULTADO=4.
- ESPERA_A: btn0 -> A<=switches, go ESPERA_B. btn1/btn2 -> o_error, stay.
- ESPERA_B: btn0 -> reload A, stay. btn1 -> B<=switches, go ESPERA_OP. btn2 -> o_error.
- ESPERA_OP: btn0/btn1 -> reload A/B, stay. btn2 -> opcode<=switches[CANT_BIT_OPCODE-1:0], go EJECUTAR.
- EJECUTAR: single cycle, no inputs accepted (pulses dropped silently). o_resultado<=i_resultado; go RESULTADO. o_resultado_valido rises at the same edge.
- RESULTADO: valid held high. btn0 -> load A, valid<=0, go ESPERA_B. btn1 -> load B, valid<=0, go ESPERA_OP. btn2 -> load opcode, valid<=0, go EJECUTAR (re-execute).
- btn3 (cancel) alone, any state except EJECUTAR: go ESPERA_A, valid<=0; operand/opcode/result registers keep their values.
- o_resultado_valido is 0 in every state except RESULTADO.
- Unused state encodings 5..7 -> ESPERA_A next cycle, valid 0.

Decomposition:
- Package alu_secuenciador_pkg: state localparams (ESPERA_A..RESULTADO), button indices (BTN_A=0, BTN_B=1, BTN_OP=2, BTN_CANCELAR=3), state width 3.
- Sub-module antirrebote (synchronizer + debounce counter + rising-edge pulse), instantiated once per button via generate. FSM and registers stay in alu_secuenciador.

Test Plan:
- Reset: drive raw buttons, apply i_reset -> all outputs 0, o_estado=0. Release with btn0 held -> A loads after debounce.
- Full sequence (N=4): sw=3 btn0, sw=5 btn1, sw=4 btn2, ALU model returns 8 -> A=3, B=5, opcode=4. o_resultado=8 and valid=1 one edge after EJECUTAR. Each load lands exactly 7 edges after the raw press.
- Bounce: btn0 pulses high for 3 cycles, low 1, high 3 -> no load. Then held 4 cycles -> exactly one load, one pulse.
- Order errors: btn2 in ESPERA_A -> o_error 1 cycle, opcode stays 0. btn0+btn1 simultaneously in ESPERA_B -> o_error, A/B unchanged.
- Cancel: from ESPERA_OP press btn3 -> o_estado=0, valid 0, A/B retained. From RESULTADO press btn3 -> valid drops same edge.
- Re-execute: in RESULTADO with sw=2 press btn2 -> valid drops, EJECUTAR, then new result captured and valid=1.
